subgroup_rr_scheduler: RTL and testbench
========================================

Name: subgroup_rr_scheduler

Overview:
- Round-robin scheduler that shares one resource slot among the NUM_REQ child instances of a hierarchy node. The default of 5 matches the 5-wide fan-out of every node.
- Sits beside the child instances at each node. Each child raises a request. Exactly one child holds the grant at a time.
- A grant ends on the holder's done, on the holder's request dropping, or on a hold-timeout.

Parameters:
- NUM_REQ, 5, number of requesting children (2..16).
- MAX_HOLD, 16, maximum cycles a grant may be held before forced revocation (>=2).
- IDX_W, $clog2(NUM_REQ), width of the grant index.
- CNT_W, $clog2(MAX_HOLD), width of the hold counter.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-child request, level-sensitive.
- done  input  1  the current holder finishes; sampled only in GRANT.
- gnt  output  NUM_REQ  one-hot grant, registered.
- gnt_idx  output  IDX_W  binary index of the granted child; valid while busy.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.
- hold_cnt  output  CNT_W  cycles elapsed in the current grant.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - gnt=0, gnt_idx=0, busy=0, timeout=0, hold_cnt=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - Reset mid-grant drops gnt at that edge; no timeout pulse.
- Outputs: all registered, no combinational input-to-output paths.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, select the first set bit searching ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1 (wrap-around).
  - Next edge: gnt=onehot(sel), gnt_idx=sel, busy=1, hold_cnt=0, go GRANT.
  - Latency: request to grant is 1 cycle.
  - If req=0, stay IDLE.
- GRANT, each cycle, with i=gnt_idx. Terminate if any of:
  - (a) done=1;
  - (b) req[i]=0;
  - (c) hold_cnt==MAX_HOLD-1.
- On termination, at the next edge:
  - gnt=0, busy=0, ptr=(i+1) mod NUM_REQ, go IDLE.
  - timeout=1 for one cycle only if (c) and neither (a) nor (b) held.
  - Otherwise hold_cnt increments by 1, saturating is not needed because (c) bounds it.
- Simultaneous termination events: done/req-drop take priority over timeout, so no pulse.
- Dead cycle: every grant is followed by exactly one IDLE cycle (gnt=0) before the next grant. Arbitration runs in that IDLE cycle.
- Fairness: a child continuously requesting is granted within NUM_REQ-1 other grants.
- Request changes of non-holders during GRANT are ignored until IDLE.
- done in IDLE is ignored.
- ptr advances only on grant termination, never on reset-less idle cycles.
- Invariant: popcount(gnt)<=1 at all times; busy==(gnt!=0).

Test Plan:
- Reset, then req=5'b00100 held, done pulsed at cycle 3 of the grant.
  - gnt=00100 and gnt_idx=2 one cycle after req.
  - gnt=0 the cycle after done.
  - Next grant back to child 2 after one dead cycle, with ptr=3 skipping to 2.
- req=5'b11111 held, done asserted every grant at hold_cnt=0.
  - Grant order 0,1,2,3,4,0, with gnt=0 between each grant.
- req=5'b10001 with ptr=4 (after a grant to child 3).
  - Grant child 4, then child 0 (wrap).
- req=5'b00010 held, done never asserted, MAX_HOLD=16.
  - gnt held 16 cycles (hold_cnt 0..15), then gnt=0 with timeout=1 for exactly one cycle.
  - Re-granted after the dead cycle.
- Holder drops req and asserts done in the same cycle that hold_cnt==15.
  - Grant ends with timeout=0.
- rst=1 mid-grant (child 3, hold_cnt=5).
  - At that edge gnt=0, busy=0, hold_cnt=0, ptr=0.
  - With req=11111 afterward, the first grant goes to child 0.

Source files
------------

// File: rtl/subgroup_rr_scheduler.sv
// Round-robin grant of one shared resource slot among the NUM_REQ children of a
// hierarchy node; a grant ends on done, on the holder dropping its request, or on a hold timeout.
module subgroup_rr_scheduler #(
    parameter int NUM_REQ  = 5,
    parameter int MAX_HOLD = 16,
    parameter int IDX_W    = $clog2(NUM_REQ),
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               busy,
    output logic               timeout,
    output logic [CNT_W-1:0]   hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   ptr, ptr_nx;
    logic [NUM_REQ-1:0] gnt_nx;
    logic [IDX_W-1:0]   gnt_idx_nx;
    logic               busy_nx;
    logic               timeout_nx;
    logic [CNT_W-1:0]   hold_cnt_nx;

    // Wrap-around search split in two: lowest request at or above ptr wins,
    // otherwise the lowest request overall.
    logic               hi_found, lo_found;
    logic [IDX_W-1:0]   hi_idx, lo_idx, sel_idx;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(k);
                if (k >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(k);
                end
            end
        end
        sel_idx = hi_found ? hi_idx : lo_idx;
    end

    logic holder_req;
    logic end_release;
    logic end_hold;

    // gnt is one-hot on the holder, so masking req with it yields the holder's request.
    assign holder_req  = |(req & gnt);
    assign end_release = done || !holder_req;
    assign end_hold    = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        gnt_nx      = gnt;
        gnt_idx_nx  = gnt_idx;
        busy_nx     = busy;
        timeout_nx  = 1'b0;
        hold_cnt_nx = hold_cnt;
        case (state)
            IDLE: begin
                hold_cnt_nx = '0;
                if (lo_found) begin
                    state_nx   = GRANT;
                    gnt_nx     = NUM_REQ'(1) << sel_idx;
                    gnt_idx_nx = sel_idx;
                    busy_nx    = 1'b1;
                end
            end
            GRANT: begin
                if (end_release || end_hold) begin
                    state_nx    = IDLE;
                    gnt_nx      = '0;
                    busy_nx     = 1'b0;
                    hold_cnt_nx = '0;
                    // A release in the same cycle as the limit is a normal end, not a revocation.
                    timeout_nx  = end_hold && !end_release;
                    ptr_nx      = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                end else begin
                    hold_cnt_nx = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            gnt      <= gnt_nx;
            gnt_idx  <= gnt_idx_nx;
            busy     <= busy_nx;
            timeout  <= timeout_nx;
            hold_cnt <= hold_cnt_nx;
        end
    end

endmodule

// File: tb/tb_subgroup_rr_scheduler.sv
// Bench for subgroup_rr_scheduler: directed scenarios with constant expectations,
// then random traffic against a holder/pointer reference model.
module tb_subgroup_rr_scheduler;

    localparam int N  = 5;
    localparam int MH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_idx;
    logic         busy;
    logic         timeout;
    logic [3:0]   hold_cnt;

    int total = 0;
    int bad   = 0;

    // reference model: which child holds the slot (-1 = none)
    int m_holder = -1;
    int m_ptr    = 0;
    int m_cnt    = 0;
    int m_idx    = 0;
    bit m_to     = 1'b0;

    subgroup_rr_scheduler #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [N-1:0] r, input logic d, input logic rs);
        if (rs) begin
            m_holder = -1; m_ptr = 0; m_cnt = 0; m_idx = 0; m_to = 1'b0;
        end else if (m_holder < 0) begin
            m_to = 1'b0;
            m_cnt = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (m_holder < 0 && r[j]) begin
                    m_holder = j;
                    m_idx = j;
                end
            end
        end else begin
            bit rel, lim;
            rel = d || !r[m_holder];
            lim = (m_cnt == MH - 1);
            if (rel || lim) begin
                m_to = lim && !rel;
                m_ptr = (m_holder + 1) % N;
                m_holder = -1;
                m_cnt = 0;
            end else begin
                m_to = 1'b0;
                m_cnt++;
            end
        end
    endtask

    task automatic tick(input logic [N-1:0] r, input logic d, input logic rs);
        req = r; done = d; rst = rs;
        @(posedge clk);
        model_step(r, d, rs);
        #1;
    endtask

    task automatic test_reset;
        tick('0, 1'b0, 1'b1);
        tick('0, 1'b0, 1'b1);
        total++; if (gnt !== 5'b0)    begin bad++; $display("FAIL reset_gnt got=%b exp=00000", gnt); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (gnt_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", gnt_idx); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        total++; if (hold_cnt !== 4'd0) begin bad++; $display("FAIL reset_hold got=%0d exp=0", hold_cnt); end
        tick('0, 1'b0, 1'b0);
        total++; if (gnt !== 5'b0) begin bad++; $display("FAIL idle_no_req got=%b exp=00000", gnt); end
    endtask

    task automatic test_single_done;
        tick(5'b00100, 1'b0, 1'b0);
        total++; if (gnt !== 5'b00100 || gnt_idx !== 3'd2 || busy !== 1'b1)
            begin bad++; $display("FAIL single_grant got=%b/%0d/%b exp=00100/2/1", gnt, gnt_idx, busy); end
        tick(5'b00100, 1'b0, 1'b0);
        tick(5'b00100, 1'b0, 1'b0);
        total++; if (hold_cnt !== 4'd2 || gnt !== 5'b00100)
            begin bad++; $display("FAIL single_hold got=%0d/%b exp=2/00100", hold_cnt, gnt); end
        tick(5'b00100, 1'b1, 1'b0);
        total++; if (gnt !== 5'b0 || busy !== 1'b0 || timeout !== 1'b0)
            begin bad++; $display("FAIL single_done got=%b/%b/%b exp=00000/0/0", gnt, busy, timeout); end
        tick(5'b00100, 1'b0, 1'b0);
        total++; if (gnt !== 5'b00100 || gnt_idx !== 3'd2)
            begin bad++; $display("FAIL single_regrant got=%b/%0d exp=00100/2", gnt, gnt_idx); end
        tick(5'b00100, 1'b1, 1'b0);
    endtask

    task automatic test_rr_order;
        int order [6] = '{0, 1, 2, 3, 4, 0};
        tick('0, 1'b0, 1'b1);
        foreach (order[g]) begin
            logic [N-1:0] e;
            e = N'(1) << order[g];
            tick(5'b11111, 1'b1, 1'b0);
            total++; if (gnt !== e || gnt_idx !== 3'(order[g]))
                begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", g, gnt, e); end
            tick(5'b11111, 1'b1, 1'b0);
            total++; if (gnt !== 5'b0)
                begin bad++; $display("FAIL rr_dead%0d got=%b exp=00000", g, gnt); end
        end
    endtask

    task automatic test_wrap;
        tick('0, 1'b0, 1'b1);
        tick(5'b01000, 1'b0, 1'b0);
        tick(5'b01000, 1'b1, 1'b0);
        tick(5'b10001, 1'b0, 1'b0);
        total++; if (gnt !== 5'b10000 || gnt_idx !== 3'd4)
            begin bad++; $display("FAIL wrap_first got=%b/%0d exp=10000/4", gnt, gnt_idx); end
        tick(5'b10001, 1'b1, 1'b0);
        tick(5'b10001, 1'b0, 1'b0);
        total++; if (gnt !== 5'b00001 || gnt_idx !== 3'd0)
            begin bad++; $display("FAIL wrap_second got=%b/%0d exp=00001/0", gnt, gnt_idx); end
        tick(5'b10001, 1'b1, 1'b0);
        tick('0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        int held = 0;
        tick(5'b00010, 1'b0, 1'b0);
        for (int c = 0; c < 20 && gnt === 5'b00010; c++) begin
            total++; if (hold_cnt !== 4'(c) || timeout !== 1'b0)
                begin bad++; $display("FAIL to_hold%0d got=%0d/%b exp=%0d/0", c, hold_cnt, timeout, c); end
            held++;
            tick(5'b00010, 1'b0, 1'b0);
        end
        total++; if (held != MH)
            begin bad++; $display("FAIL to_length got=%0d exp=%0d", held, MH); end
        total++; if (gnt !== 5'b0 || timeout !== 1'b1)
            begin bad++; $display("FAIL to_pulse got=%b/%b exp=00000/1", gnt, timeout); end
        tick(5'b00010, 1'b0, 1'b0);
        total++; if (gnt !== 5'b00010 || timeout !== 1'b0)
            begin bad++; $display("FAIL to_regrant got=%b/%b exp=00010/0", gnt, timeout); end
    endtask

    task automatic test_simul_term;
        // continues the grant to child 1 left by test_timeout
        for (int c = 0; c < MH - 1; c++) tick(5'b00010, 1'b0, 1'b0);
        total++; if (hold_cnt !== 4'd15 || gnt !== 5'b00010)
            begin bad++; $display("FAIL simul_setup got=%0d/%b exp=15/00010", hold_cnt, gnt); end
        tick(5'b00000, 1'b1, 1'b0);
        total++; if (gnt !== 5'b0 || timeout !== 1'b0)
            begin bad++; $display("FAIL simul_end got=%b/%b exp=00000/0", gnt, timeout); end
        tick('0, 1'b0, 1'b0);
        total++; if (timeout !== 1'b0)
            begin bad++; $display("FAIL simul_late got=%b exp=0", timeout); end
    endtask

    task automatic test_reset_mid;
        tick('0, 1'b0, 1'b1);
        tick(5'b01000, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) tick(5'b01000, 1'b0, 1'b0);
        total++; if (gnt !== 5'b01000 || hold_cnt !== 4'd5)
            begin bad++; $display("FAIL mid_setup got=%b/%0d exp=01000/5", gnt, hold_cnt); end
        tick(5'b11111, 1'b0, 1'b1);
        total++; if (gnt !== 5'b0 || busy !== 1'b0 || hold_cnt !== 4'd0 || timeout !== 1'b0)
            begin bad++; $display("FAIL mid_reset got=%b/%b/%0d/%b exp=00000/0/0/0", gnt, busy, hold_cnt, timeout); end
        tick(5'b11111, 1'b0, 1'b0);
        total++; if (gnt !== 5'b00001 || gnt_idx !== 3'd0)
            begin bad++; $display("FAIL mid_first got=%b/%0d exp=00001/0", gnt, gnt_idx); end
    endtask

    task automatic test_random;
        logic [N-1:0] r = '0;
        int errs = 0;
        tick('0, 1'b0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] eg;
            logic d, rs;
            if ($urandom_range(7) == 0) r = N'($urandom);
            d  = ($urandom_range(19) == 0);
            rs = ($urandom_range(299) == 0);
            tick(r, d, rs);
            eg = (m_holder < 0) ? '0 : N'(1) << m_holder;
            total++;
            if (gnt !== eg || busy !== (m_holder >= 0) || timeout !== m_to ||
                hold_cnt !== 4'(m_cnt) || (m_holder >= 0 && gnt_idx !== 3'(m_idx)) ||
                $countones(gnt) > 1) begin
                bad++;
                if (errs < 10)
                    $display("FAIL rand_c%0d got=%b/%0d/%b/%b/%0d exp=%b/%0d/%b/%b/%0d", c,
                             gnt, gnt_idx, busy, timeout, hold_cnt,
                             eg, m_idx, (m_holder >= 0), m_to, m_cnt);
                errs++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;
        test_reset;
        test_single_done;
        test_rr_order;
        test_wrap;
        test_timeout;
        test_simul_term;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
